// File: rtl/ps2_cmd_sequencer_if.sv
// Command, transmitter and receiver signals around the PS/2 command sequencer.
// master = host/transmitter/receiver side, slave = the sequencer itself.
interface ps2_cmd_sequencer_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] arg_byte;
  logic       cmd_ready;
  logic       tx_idle;
  logic       tx_finished;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, arg_byte,
    output tx_idle, tx_finished, rx_data, rx_done,
    input  cmd_ready, tx_data, tx_wr, busy, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, arg_byte,
    input  tx_idle, tx_finished, rx_data, rx_done,
    output cmd_ready, tx_data, tx_wr, busy, done, err, err_code
  );
endinterface

// File: rtl/ps2_cmd_sequencer.sv
// Sends a PS/2 command (plus optional argument), waits for ACK per byte, resends on 0xFE/timeout.
// tx_wr one cycle after accept when tx_idle; done/err one cycle after the deciding event; one command at a time.
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  ps2_cmd_sequencer_if.slave bus
);

  localparam int TO_W = (ACK_TIMEOUT_CYCLES > 1) ? $clog2(ACK_TIMEOUT_CYCLES) : 1;
  localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRIES);

  localparam logic [1:0] E_NONE    = 2'b00;
  localparam logic [1:0] E_RESEND  = 2'b01;
  localparam logic [1:0] E_TIMEOUT = 2'b10;
  localparam logic [1:0] E_KBD     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_TX,
    S_WAIT_ACK,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [7:0]      cmd_r;
  logic [7:0]      arg_r;
  logic            has_arg_r;
  logic            phase;
  logic [RC_W-1:0] retry_cnt;
  logic [TO_W-1:0] to_cnt;

  logic [7:0]      tx_data_r;
  logic            tx_wr_r;
  logic            done_r;
  logic            err_r;
  logic [1:0]      err_code_r;
  logic            busy_r;
  logic            cmd_ready_r;

  logic            to_hit;
  logic            rx_ack;
  logic            rx_resend;
  logic            rx_abort;
  logic            retry_req;
  logic [1:0]      retry_code;

  assign bus.tx_data   = tx_data_r;
  assign bus.tx_wr     = tx_wr_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.err_code  = err_code_r;
  assign bus.busy      = busy_r;
  assign bus.cmd_ready = cmd_ready_r;

  // A terminating rx/tx event in the same cycle always wins over the timeout.
  always_comb begin
    to_hit     = (to_cnt >= TO_LAST);
    rx_ack     = bus.rx_done && (bus.rx_data == 8'hFA);
    rx_resend  = bus.rx_done && (bus.rx_data == 8'hFE);
    rx_abort   = bus.rx_done && ((bus.rx_data == 8'hFC) || (bus.rx_data == 8'hFD));
    retry_req  = 1'b0;
    retry_code = E_NONE;
    if ((state == S_WAIT_ACK) && rx_resend) begin
      retry_req  = 1'b1;
      retry_code = E_RESEND;
    end else if (to_hit &&
                 (((state == S_WAIT_TX) && !bus.tx_finished) ||
                  ((state == S_WAIT_ACK) && !rx_ack && !rx_abort))) begin
      retry_req  = 1'b1;
      retry_code = E_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cmd_r       <= 8'h00;
      arg_r       <= 8'h00;
      has_arg_r   <= 1'b0;
      phase       <= 1'b0;
      retry_cnt   <= '0;
      to_cnt      <= '0;
      tx_data_r   <= 8'h00;
      tx_wr_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= E_NONE;
      busy_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      tx_wr_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_r       <= bus.cmd_byte;
            arg_r       <= bus.arg_byte;
            has_arg_r   <= bus.cmd_has_arg;
            phase       <= 1'b0;
            retry_cnt   <= '0;
            err_code_r  <= E_NONE;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            state       <= S_LOAD;
          end
        end

        S_LOAD: begin
          tx_data_r <= phase ? arg_r : cmd_r;
          if (bus.tx_idle) begin
            tx_wr_r <= 1'b1;
            to_cnt  <= '0;
            state   <= S_WAIT_TX;
          end
        end

        S_WAIT_TX: begin
          if (bus.tx_finished) begin
            state <= S_WAIT_ACK;
            // Saturate so a finish on the last allowed cycle still times out in WAIT_ACK.
            if (!to_hit) to_cnt <= to_cnt + 1'b1;
          end else if (!retry_req) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_WAIT_ACK: begin
          if (rx_ack) begin
            if (!phase && has_arg_r) begin
              phase     <= 1'b1;
              retry_cnt <= '0;
              state     <= S_LOAD;
            end else begin
              done_r <= 1'b1;
              state  <= S_DONE;
            end
          end else if (rx_abort) begin
            err_r      <= 1'b1;
            err_code_r <= E_KBD;
            state      <= S_ERR;
          end else if (!retry_req) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_DONE, S_ERR: begin
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      // Branches above never touch state when retry_req is set, so this is the only writer then.
      if (retry_req) begin
        if (retry_cnt < RC_MAX) begin
          retry_cnt <= retry_cnt + 1'b1;
          state     <= S_LOAD;
        end else begin
          err_r      <= 1'b1;
          err_code_r <= retry_code;
          state      <= S_ERR;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench: a plan model predicts sends/results per command; a monitor checks DUT outputs against it.
`timescale 1ns/1ps
module tb_ps2_cmd_sequencer;
  localparam int T   = 100;
  localparam int MR  = 3;
  localparam int SIL = -1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ps2_cmd_sequencer_if bus();

  ps2_cmd_sequencer #(.ACK_TIMEOUT_CYCLES(T), .MAX_RETRIES(MR)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct { int kind; int val; } ev_t;   // kind 0 = tx byte, 1 = done, 2 = err(code)

  ev_t  exp_q[$];
  int   resp_q[$];
  int   forced_q[$];
  int   tx_cyc_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_rx_cyc = 0;
  int   ends_seen = 0;
  int   ends_issued = 0;
  int   tx_seen = 0;
  bit   hold_low = 0;
  bit   force_junk = 0;
  bit   tx_done_flag = 0;
  logic idle_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    idle_at_edge <= bus.tx_idle;
  end

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Keyboard response for one send: forced script entry if present, else weighted random.
  function automatic int pick();
    int r;
    if (forced_q.size() > 0) return forced_q.pop_front();
    r = int'($urandom_range(0, 99));
    if (r < 55) return 'hFA;
    if (r < 80) return 'hFE;
    if (r < 90) return SIL;
    if (r < 95) return 'hFC;
    return 'hFD;
  endfunction

  // Reference model: walk bytes, each send consumes one response; decide result from the protocol rules.
  task automatic plan(input logic [7:0] c, input logic [7:0] a, input bit has);
    logic [7:0] seq[$];
    int tries;
    int r;
    bit acked;
    seq.push_back(c);
    if (has) seq.push_back(a);
    foreach (seq[i]) begin
      tries = 0;
      acked = 0;
      while (!acked) begin
        r = pick();
        resp_q.push_back(r);
        exp_q.push_back('{kind: 0, val: int'(seq[i])});
        if (r == 'hFA) acked = 1;
        else if (r == 'hFC || r == 'hFD) begin
          exp_q.push_back('{kind: 2, val: 3});
          return;
        end else if (tries < MR) tries++;
        else begin
          exp_q.push_back('{kind: 2, val: (r == 'hFE) ? 1 : 2});
          return;
        end
      end
    end
    exp_q.push_back('{kind: 1, val: 0});
  endtask

  task automatic pop_check(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_output: got event kind %0d value 0x%0h, expected no event (cycle %0d)", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == kind) chk(kind == 0 ? "tx_data" : (kind == 2 ? "err_code" : "done_value"), val, e.val);
    end
  endtask

  // Transmitter + keyboard model.
  initial begin : xmit_kbd
    int tx_cnt;
    int rx_cnt;
    int cur;
    bit junk;
    tx_cnt = 0; rx_cnt = 0; cur = SIL; junk = 0;
    bus.tx_idle = 1'b1; bus.tx_finished = 1'b0; bus.rx_done = 1'b0; bus.rx_data = 8'h00;
    forever begin
      @(negedge clk);
      bus.tx_finished = 1'b0;
      bus.rx_done     = 1'b0;
      if (!reset_n) begin
        tx_cnt = 0;
        rx_cnt = 0;
      end else if (bus.tx_wr) begin
        tx_cnt = int'($urandom_range(1, 5));
        cur    = (resp_q.size() > 0) ? resp_q.pop_front() : SIL;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          bus.tx_finished = 1'b1;
          tx_done_flag    = 1;
          if (cur != SIL) begin
            rx_cnt = int'($urandom_range(2, 10));
            junk   = force_junk || ($urandom_range(0, 3) == 0);
          end
        end
      end else if (rx_cnt > 0) begin
        rx_cnt--;
        if (rx_cnt == 0) begin
          bus.rx_done = 1'b1;
          bus.rx_data = cur[7:0];
          last_rx_cyc = cyc;
        end else if (junk && rx_cnt == 1) begin
          bus.rx_done = 1'b1;
          bus.rx_data = 8'hAA;
          last_rx_cyc = cyc;
        end
      end
      bus.tx_idle = (tx_cnt == 0) && !hold_low;
    end
  end

  // Monitor: every DUT output event is matched against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.tx_wr) begin
          tx_seen++;
          tx_cyc_q.push_back(cyc);
          chk("tx_wr_only_when_tx_idle", int'(idle_at_edge), 1);
          pop_check(0, int'(bus.tx_data));
        end
        if (bus.done) begin
          pop_check(1, 0);
          chk("done_one_cycle_after_rx", cyc, last_rx_cyc + 1);
          ends_seen++;
        end
        if (bus.err) begin
          pop_check(2, int'(bus.err_code));
          if (bus.err_code != 2'b10) chk("err_one_cycle_after_rx", cyc, last_rx_cyc + 1);
          ends_seen++;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1);
  end

  task automatic issue(input logic [7:0] c, input logic [7:0] a, input bit has, output int acc_cyc);
    for (int i = 0; i < 2000 && !bus.cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_before_issue", int'(bus.cmd_ready), 1);
    plan(c, a, has);
    ends_issued++;
    bus.cmd_valid   = 1'b1;
    bus.cmd_byte    = c;
    bus.arg_byte    = a;
    bus.cmd_has_arg = has;
    acc_cyc         = cyc;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    bus.cmd_byte    = 8'($urandom);
    bus.arg_byte    = 8'($urandom);
    bus.cmd_has_arg = 1'($urandom);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 3000 && ends_seen != ends_issued; i++) @(negedge clk);
    chk("command_completed", ends_seen, ends_issued);
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    resp_q.delete();
    forced_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
    chk({tag, "_busy"},      int'(bus.busy), 0);
    chk({tag, "_tx_wr"},     int'(bus.tx_wr), 0);
    chk({tag, "_tx_data"},   int'(bus.tx_data), 0);
    chk({tag, "_done"},      int'(bus.done), 0);
    chk({tag, "_err"},       int'(bus.err), 0);
    chk({tag, "_err_code"},  int'(bus.err_code), 0);
  endtask

  initial begin : stimulus
    int acc;
    int n0;
    int gap;
    bus.cmd_valid = 1'b0; bus.cmd_byte = 8'h00; bus.arg_byte = 8'h00; bus.cmd_has_arg = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain command, single ACK.
    tx_cyc_q.delete();
    forced_q.push_back('hFA);
    issue(8'hF4, 8'h00, 1'b0, acc);
    wait_end();
    chk("first_tx_latency", (tx_cyc_q.size() > 0) ? tx_cyc_q[0] : -1, acc + 2);
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    chk("err_code_after_done", int'(bus.err_code), 0);

    // Command + argument with junk bytes injected before each ACK.
    force_junk = 1;
    forced_q.push_back('hFA); forced_q.push_back('hFA);
    issue(8'hED, 8'h05, 1'b1, acc);
    wait_end();
    force_junk = 0;

    // Two resends then success.
    forced_q.push_back('hFE); forced_q.push_back('hFE); forced_q.push_back('hFA); forced_q.push_back('hFA);
    issue(8'hED, 8'h02, 1'b1, acc);
    wait_end();

    // Resends exhausted.
    repeat (4) forced_q.push_back('hFE);
    issue(8'hED, 8'h07, 1'b1, acc);
    wait_end();
    repeat (3) @(negedge clk);
    chk("err_code_held_resend", int'(bus.err_code), 1);

    // Silent keyboard: timeouts exhausted.
    tx_cyc_q.delete();
    repeat (4) forced_q.push_back(SIL);
    issue(8'hF5, 8'h00, 1'b0, acc);
    wait_end();
    chk("timeout_send_count", tx_cyc_q.size(), 4);
    for (int i = 1; i < tx_cyc_q.size(); i++) begin
      gap = tx_cyc_q[i] - tx_cyc_q[i-1];
      chk("timeout_resend_gap_in_range", int'(gap >= T && gap <= T + 2), 1);
    end
    chk("err_code_held_timeout", int'(bus.err_code), 2);

    // Keyboard error byte.
    forced_q.push_back('hFC);
    issue(8'hFF, 8'h00, 1'b0, acc);
    wait_end();

    // Transmitter busy after acceptance, and cmd_valid while busy.
    hold_low = 1;
    @(negedge clk);
    @(negedge clk);
    forced_q.push_back('hFA); forced_q.push_back('hFA);
    issue(8'hF3, 8'h2A, 1'b1, acc);
    chk("err_code_cleared_on_accept", int'(bus.err_code), 0);
    n0 = tx_seen;
    repeat (50) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_byte  = 8'h11;
      @(negedge clk);
    end
    chk("no_tx_while_tx_busy", tx_seen, n0);
    chk("busy_while_waiting", int'(bus.busy), 1);
    bus.cmd_valid = 1'b0;
    hold_low = 0;
    wait_end();

    // Randomized commands.
    repeat (40) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom), acc);
      wait_end();
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Reset in WAIT_ACK after an error left err_code set.
    forced_q.push_back('hFD);
    issue(8'hEE, 8'h00, 1'b0, acc);
    wait_end();
    chk("err_code_before_reset", int'(bus.err_code), 3);
    for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
    exp_q.push_back('{kind: 0, val: 'hF2});
    resp_q.push_back(SIL);
    tx_done_flag    = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_byte    = 8'hF2;
    bus.cmd_has_arg = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && !tx_done_flag; i++) @(negedge clk);
    chk("reached_wait_ack", int'(tx_done_flag), 1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midcmd_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (250) @(negedge clk);
    chk("no_event_after_reset", exp_q.size(), 0);
    chk("idle_after_reset", int'(bus.cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Host-to-keyboard command controller that sits above the PS/2 transmitter and beside the PS/2 receiver. It accepts one command, with an optional argument byte (e.g. 0xED + LED mask, 0xF3 + typematic rate), and sequences each byte through the transmitter. After each byte it waits for the keyboard's 0xFA ACK, resends on 0xFE, and aborts on 0xFC, timeout or retry exhaustion. It reports a single done/error result per command.

Parameters:
ACK_TIMEOUT_CYCLES, 2000000, clk cycles allowed from tx_wr pulse to ACK receipt (20 ms at 100 MHz)
MAX_RETRIES, 3, resends allowed per byte after 0xFE or timeout before error

Ports:
clk  input  1  system clock, 100 MHz
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request; sampled only when cmd_ready=1
cmd_byte  input  8  command byte
cmd_has_arg  input  1  1 = send arg_byte after command ACK
arg_byte  input  8  argument byte
cmd_ready  output  1  1 in IDLE only
tx_idle  input  1  transmitter idle status
tx_finished  input  1  transmitter one-cycle completion pulse
tx_data  output  8  byte to transmitter data_in
tx_wr  output  1  one-cycle write strobe to transmitter w_enable
rx_data  input  8  received byte from PS/2 receiver
rx_done  input  1  one-cycle strobe, rx_data valid
busy  output  1  command in progress (not IDLE)
done  output  1  one-cycle pulse: command (and arg) fully ACKed
err  output  1  one-cycle pulse: command aborted
err_code  output  2  held from err until next accepted command: 01 retries exhausted on 0xFE, 10 timeout exhausted, 11 keyboard 0xFC/0xFD, 00 none

Behaviour:
- Reset (async, reset_n=0): state IDLE; tx_wr=0, tx_data=0, done=0, err=0, err_code=00, busy=0, cmd_ready=1; all counters 0. Reset mid-command abandons it with no done/err pulse.
- Latched regs: cmd_r, arg_r, has_arg_r, phase (0=cmd, 1=arg), retry_cnt (width clog2(MAX_RETRIES+1)), to_cnt (width clog2(ACK_TIMEOUT_CYCLES)).
- IDLE: cmd_ready=1. On cmd_valid: latch cmd_byte, arg_byte, cmd_has_arg; phase=0; retry_cnt=0; err_code=00; go LOAD.
- LOAD: tx_data = phase ? arg_r : cmd_r. Wait for tx_idle=1. Then tx_wr=1 for exactly one cycle, to_cnt=0, go WAIT_TX. tx_wr is never asserted while tx_idle=0.
- WAIT_TX: to_cnt increments each cycle. On tx_finished, go WAIT_ACK. rx_done is ignored here.
- WAIT_ACK: to_cnt continues incrementing. rx_done with rx_data:
  - 0xFA: if phase=0 and has_arg_r, set phase=1, retry_cnt=0, go LOAD. Otherwise go DONE.
  - 0xFE: resend the same byte; see Retry.
  - 0xFC or 0xFD: go ERR with code 11.
  - Any other byte: ignored, no state change.
- Timeout: in WAIT_TX or WAIT_ACK, when to_cnt reaches ACK_TIMEOUT_CYCLES-1 without a terminating event, apply Retry with code 10.
- Same-cycle priority: rx_done/tx_finished take priority over timeout in the same cycle.
- Retry: if retry_cnt < MAX_RETRIES, increment retry_cnt and go LOAD with the same phase. Otherwise go ERR, with code 01 (after 0xFE) or 10 (after timeout).
- DONE: done=1 for one cycle, then IDLE. ERR: err=1 for one cycle, err_code set, then IDLE.
- tx_data holds its value from LOAD through WAIT_ACK.
- cmd_valid is ignored outside IDLE; no queuing.
- Latency, ideal case (tx_idle=1): tx_wr asserts 1 cycle after acceptance. done asserts 1 cycle after the final ACK rx_done.

Test Plan:
- cmd 0xF4, no arg; tx_finished, then rx 0xFA -> exactly one tx_wr with tx_data=0xF4, done pulse 1 cycle after rx_done, err_code=00, busy low afterwards.
- cmd 0xED, arg 0x05; ACK each byte -> tx_wr sequence 0xED then 0x05, done once; an rx 0xAA injected during WAIT_ACK is ignored.
- cmd 0xED; respond 0xFE twice, then 0xFA; arg ACKed -> 0xED sent 3 times, done; with MAX_RETRIES=3 and 4×0xFE -> 4 sends, err with err_code=01.
- ACK_TIMEOUT_CYCLES=100, keyboard silent -> resend every 100 cycles, 4 tx_wr total, then err with err_code=10; rx 0xFC instead -> immediate err with code 11.
- tx_idle held low 50 cycles after acceptance -> tx_wr delayed until tx_idle=1; cmd_valid while busy -> ignored.
- reset_n pulsed low in WAIT_ACK -> all outputs return to reset values asynchronously, no done/err, cmd_ready=1.
